// File: rtl/sample_serial_tx.sv
// sample_serial_tx: FIFO-buffered mono sample serializer onto a left-justified bclk/lrclk/sdata link.
// Each popped sample is sent MSB-first in the left slot, then again in the right slot.
module sample_serial_tx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int BCLK_DIV     = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              sample_clock,
  input  logic                              reset,
  input  logic [SAMPLE_WIDTH-1:0]           sample_in,
  input  logic                              sample_valid,
  output logic                              sample_ready,
  input  logic                              enable,
  output logic                              bclk,
  output logic                              lrclk,
  output logic                              sdata,
  output logic                              underrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int DW = $clog2(BCLK_DIV+1);
  localparam int BW = $clog2(SAMPLE_WIDTH+1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV-1);
  localparam logic [BW-1:0] BIT_LAST = BW'(SAMPLE_WIDTH-1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state;
  logic [SW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic [SW-1:0] r_shreg, w_shreg, r_cur, w_cur, w_head;
  logic [DW-1:0] r_div, w_div;
  logic [BW-1:0] r_bit, w_bit;
  logic          r_bclk, w_bclk, r_lr, w_lr, r_sd, w_sd, r_und, w_und;
  logic          w_empty, w_push, w_pop, w_wrap, w_fall, w_slot_end, w_start, w_stop;

  assign w_empty      = r_level == '0;
  assign sample_ready = r_level != FULL_LVL;
  assign w_push       = sample_valid && sample_ready;
  assign w_head       = w_empty ? '0 : r_mem[r_rd];
  assign w_wrap       = r_state == RUN && r_div == DIV_LAST;
  assign w_fall       = w_wrap && r_bclk;
  assign w_slot_end   = w_fall && r_bit == BIT_LAST;
  // enable is only looked at in IDLE or on the last falling bclk of the right slot
  assign w_start      = enable && (r_state == IDLE || (w_slot_end && r_lr));
  assign w_stop       = !enable && w_slot_end && r_lr;
  assign w_pop        = w_start && !w_empty;

  always_comb begin
    w_state = r_state;
    w_shreg = r_shreg;
    w_cur   = r_cur;
    w_div   = w_wrap ? '0 : (r_state == RUN ? r_div + 1'b1 : r_div);
    w_bclk  = r_bclk ^ w_wrap;
    w_bit   = r_bit;
    w_lr    = r_lr;
    w_sd    = r_sd;
    w_und   = 1'b0;
    if (w_start || w_stop) begin
      w_state = w_start ? RUN : IDLE;
      w_shreg = w_start ? w_head : r_shreg;
      w_cur   = w_start ? w_head : r_cur;
      w_und   = w_start && w_empty;
      w_sd    = w_start && w_head[SW-1];
      w_div   = '0;
      w_bit   = '0;
      w_bclk  = 1'b0;
      w_lr    = 1'b0;
    end else if (w_slot_end) begin
      w_lr    = 1'b1;
      w_shreg = r_cur;
      w_sd    = r_cur[SW-1];
      w_bit   = '0;
    end else if (w_fall) begin
      w_shreg = r_shreg << 1;
      w_sd    = r_shreg[SW-2];
      w_bit   = r_bit + 1'b1;
    end
  end

  always_ff @(posedge sample_clock or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cur   <= '0;
      r_div   <= '0;
      r_bit   <= '0;
      r_bclk  <= 1'b0;
      r_lr    <= 1'b0;
      r_sd    <= 1'b0;
      r_und   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      r_state <= w_state;
      r_shreg <= w_shreg;
      r_cur   <= w_cur;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_bclk  <= w_bclk;
      r_lr    <= w_lr;
      r_sd    <= w_sd;
      r_und   <= w_und;
      r_wr    <= r_wr + AW'(w_push);
      r_rd    <= r_rd + AW'(w_pop);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end

  always_ff @(posedge sample_clock)
    if (w_push) r_mem[r_wr] <= sample_in;

  assign bclk       = r_bclk;
  assign lrclk      = r_lr;
  assign sdata      = r_sd;
  assign underrun   = r_und;
  assign fifo_level = r_level;
endmodule
